timekeeper_hms: RTL and testbench

Parametrised hours/minutes/seconds/sub-second timekeeper with runtime 12/24-hour display, DST adjust requests and a valid/ready time-set port. It is the next-generation time base for the display path: it counts one sub-second unit per `kh_clk` cycle and drives the packed `disp_time` bus, the AM/PM flag and the second/day strobes consumed by the display and alarm logic.

---
 rtl/timekeeper_hms.sv | 166 ++++++++++++++++
 tb/tb_timekeeper_hms.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper_hms.sv
// timekeeper_hms
//
// Hours/minutes/seconds/sub-second time base. Counts one sub-second unit per
// kh_clk cycle, keeps the hour internally in 24-hour form, and presents it in
// 12- or 24-hour form on disp_time. Accepts DST hour adjustments and a
// valid/ready time-load port.
//
// Ports
//   kh_clk      in   tick clock
//   reset_n     in   asynchronous active-low reset
//   run         in   1 = counting advances, 0 = counters hold
//   mode_24     in   1 = 24-hour display, 0 = 12-hour display
//   spring_fwd  in   single-cycle request: hour + 1
//   fall_back   in   single-cycle request: hour - 1 (once per day)
//   set_valid   in   time-load request
//   set_time    in   {hr[16:12], min[11:6], sec[5:0]}, 24-hour form
//   set_ready   out  block can accept a load
//   set_err     out  one-cycle pulse after a rejected load
//   disp_time   out  {hr(5), min(6), sec(6), sub(SUB_W)}
//   pm          out  internal hour >= 12
//   sec_pulse   out  one cycle high after each sub-second wrap
//   day_pulse   out  one cycle high after the 23:59:59 -> 00:00:00 wrap
module timekeeper_hms #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SUB_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic              kh_clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              mode_24,
  input  logic              spring_fwd,
  input  logic              fall_back,
  input  logic              set_valid,
  input  logic [16:0]       set_time,
  output logic              set_ready,
  output logic              set_err,
  output logic [16+SUB_W:0] disp_time,
  output logic              pm,
  output logic              sec_pulse,
  output logic              day_pulse
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  typedef enum logic {IDLE, BUSY} set_state_t;

  set_state_t       state, state_next;
  logic [4:0]       hr24, hr24_next;
  logic [5:0]       mn, mn_next;
  logic [5:0]       sc, sc_next;
  logic [SUB_W-1:0] sub, sub_next;
  logic             fb_done, fb_done_next;
  logic             armed;

  logic       xfer, set_bad, load, tick;
  logic       sub_wrap, sec_wrap, min_wrap, day_wrap;
  logic [4:0] hr_tick;
  logic       fb_tick, dst_fwd, dst_back;
  logic [4:0] set_hr;
  logic [5:0] set_min, set_sec;

  assign set_hr  = set_time[16:12];
  assign set_min = set_time[11:6];
  assign set_sec = set_time[5:0];

  assign set_ready = (state == IDLE);
  assign xfer      = set_valid && set_ready;
  assign set_bad   = (set_hr > 5'd23) || (set_min > 6'd59) || (set_sec > 6'd59);
  assign load      = xfer && !set_bad;

  // Ticking waits one edge after reset release so the release is synchronised.
  assign tick     = run && armed;
  assign sub_wrap = tick && (sub == SUB_LAST);
  assign sec_wrap = sub_wrap && (sc == 6'd59);
  assign min_wrap = sec_wrap && (mn == 6'd59);
  assign day_wrap = min_wrap && (hr24 == 5'd23);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned; that is what keeps latches out.
  always_comb begin
    sub_next     = sub;
    sc_next      = sc;
    mn_next      = mn;
    hr_tick      = hr24;
    fb_tick      = fb_done;
    dst_fwd      = 1'b0;
    dst_back     = 1'b0;
    hr24_next    = hr24;
    fb_done_next = fb_done;

    if (tick) sub_next = sub_wrap ? '0 : sub + 1'b1;
    if (sub_wrap) sc_next = sec_wrap ? 6'd0 : sc + 6'd1;
    if (sec_wrap) mn_next = min_wrap ? 6'd0 : mn + 6'd1;
    if (min_wrap) hr_tick = day_wrap ? 5'd0 : hr24 + 5'd1;
    if (day_wrap) fb_tick = 1'b0;

    // DST adjusts the post-tick hour; simultaneous requests cancel.
    dst_fwd  = spring_fwd && !fall_back;
    dst_back = fall_back && !spring_fwd && !fb_tick;
    if (dst_fwd)       hr24_next = (hr_tick == 5'd23) ? 5'd0 : hr_tick + 5'd1;
    else if (dst_back) hr24_next = (hr_tick == 5'd0) ? 5'd23 : hr_tick - 5'd1;
    else               hr24_next = hr_tick;
    fb_done_next = fb_tick || dst_back;

    // An accepted load overrides both DST and the tick.
    if (load) begin
      hr24_next    = set_hr;
      mn_next      = set_min;
      sc_next      = set_sec;
      sub_next     = '0;
      fb_done_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = BUSY;
      BUSY:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hr24      <= '0;
      mn        <= '0;
      sc        <= '0;
      sub       <= '0;
      fb_done   <= 1'b0;
      armed     <= 1'b0;
      set_err   <= 1'b0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      hr24      <= hr24_next;
      mn        <= mn_next;
      sc        <= sc_next;
      sub       <= sub_next;
      fb_done   <= fb_done_next;
      armed     <= 1'b1;
      set_err   <= xfer && set_bad;
      sec_pulse <= sub_wrap && !load;
      day_pulse <= day_wrap && !load;
    end
  end

  // Display hour: 12-hour form maps 0 and 12 to 12, otherwise hr24 mod 12.
  logic [4:0] disp_hr;
  always_comb begin
    disp_hr = hr24;
    if (!mode_24) begin
      if (hr24 == 5'd0 || hr24 == 5'd12) disp_hr = 5'd12;
      else if (hr24 > 5'd12)              disp_hr = hr24 - 5'd12;
      else                                disp_hr = hr24;
    end
  end

  assign disp_time = {disp_hr, mn, sc, sub};
  assign pm        = (hr24 >= 5'd12);

endmodule

// File: tb/tb_timekeeper_hms.sv
// Testbench for timekeeper_hms (TICKS_PER_SEC = 4): directed vector table,
// hand-written corner sequences and a randomized run against a reference
// model that keeps the time of day as one tick count.
module tb_timekeeper_hms;

  localparam int TPS = 4;
  localparam int SW  = $clog2(TPS);
  localparam int HT  = 3600 * TPS;   // ticks per hour
  localparam int DT  = 24 * HT;      // ticks per day

  logic          kh_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0, mode_24 = 1'b0, spring_fwd = 1'b0, fall_back = 1'b0;
  logic          set_valid = 1'b0;
  logic [16:0]   set_time = '0;
  logic          set_ready, set_err, pm, sec_pulse, day_pulse;
  logic [16+SW:0] disp_time;

  timekeeper_hms #(.TICKS_PER_SEC(TPS), .SUB_W(SW)) dut (
    .kh_clk(kh_clk), .reset_n(reset_n), .run(run), .mode_24(mode_24),
    .spring_fwd(spring_fwd), .fall_back(fall_back), .set_valid(set_valid),
    .set_time(set_time), .set_ready(set_ready), .set_err(set_err),
    .disp_time(disp_time), .pm(pm), .sec_pulse(sec_pulse), .day_pulse(day_pulse)
  );

  always #5 kh_clk = ~kh_clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge kh_clk);
    #1;
  endtask

  function automatic logic [16+SW:0] pk(input int h, input int m, input int s, input int sb);
    return {5'(h), 6'(m), 6'(s), SW'(sb)};
  endfunction

  function automatic logic [16:0] st(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  // Directed vectors: inputs applied for one edge, outputs expected after it.
  // flags = {pm, set_ready, set_err, sec_pulse, day_pulse}
  typedef struct {
    logic        run, m24, sf, fb, sv;
    logic [16:0] stime;
    int          hr, mn, sc, sb;
    logic [4:0]  flags;
  } vec_t;

  function automatic vec_t v(input logic r, input logic m24, input logic sf,
                             input logic fb, input logic sv, input int h,
                             input int m, input int s, input int ehr, input int emn,
                             input int esc, input int esb, input logic [4:0] fl);
    vec_t x;
    x.run = r; x.m24 = m24; x.sf = sf; x.fb = fb; x.sv = sv;
    x.stime = st(h, m, s);
    x.hr = ehr; x.mn = emn; x.sc = esc; x.sb = esb; x.flags = fl;
    return x;
  endfunction

  // Reference model: time of day as a single tick count.
  int m_t;
  bit m_fb, m_busy, m_armed, m_err, m_sp, m_dp;

  task automatic model_reset();
    m_t = 0; m_fb = 0; m_busy = 0; m_armed = 0; m_err = 0; m_sp = 0; m_dp = 0;
  endtask

  task automatic model_edge();
    int h, m, s;
    bit xfer, ok;
    h = int'(set_time[16:12]); m = int'(set_time[11:6]); s = int'(set_time[5:0]);
    xfer = set_valid && !m_busy;
    ok = (h <= 23) && (m <= 59) && (s <= 59);
    m_err = xfer && !ok;
    m_sp = 0; m_dp = 0;
    if (xfer && ok) begin
      m_t = ((h * 60 + m) * 60 + s) * TPS;
      m_fb = 0;
    end else begin
      if (run && m_armed) begin
        m_t++;
        if (m_t % TPS == 0) m_sp = 1;
        if (m_t == DT) begin m_t = 0; m_dp = 1; m_fb = 0; end
      end
      if (spring_fwd && !fall_back) m_t = (m_t + HT) % DT;
      else if (fall_back && !spring_fwd && !m_fb) begin
        m_t = (m_t + DT - HT) % DT;
        m_fb = 1;
      end
    end
    m_busy = xfer;
    m_armed = 1;
  endtask

  function automatic logic [16+SW:0] model_disp(input bit m24);
    int h24, h;
    h24 = m_t / HT;
    h = h24;
    if (!m24) h = (h24 % 12 == 0) ? 12 : h24 % 12;
    return pk(h, (m_t / (60 * TPS)) % 60, (m_t / TPS) % 60, m_t % TPS);
  endfunction

  vec_t tbl[22];

  initial begin
    int n;
    bit seen;

    tbl[0]  = v(0,1,0,0,1, 23,59,59, 23,59,59,0, 5'b10000);
    tbl[1]  = v(1,1,0,0,0, 0,0,0,    23,59,59,1, 5'b11000);
    tbl[2]  = v(1,1,0,0,0, 0,0,0,    23,59,59,2, 5'b11000);
    tbl[3]  = v(1,1,0,0,0, 0,0,0,    23,59,59,3, 5'b11000);
    tbl[4]  = v(1,0,0,0,0, 0,0,0,    12,0,0,0,   5'b01011);
    tbl[5]  = v(0,0,0,0,0, 0,0,0,    12,0,0,0,   5'b01000);
    tbl[6]  = v(0,0,0,0,1, 13,5,0,   1,5,0,0,    5'b10000);
    tbl[7]  = v(0,1,0,0,0, 0,0,0,    13,5,0,0,   5'b11000);
    tbl[8]  = v(0,1,0,0,1, 10,59,59, 10,59,59,0, 5'b00000);
    tbl[9]  = v(1,1,0,0,0, 0,0,0,    10,59,59,1, 5'b01000);
    tbl[10] = v(1,1,0,0,0, 0,0,0,    10,59,59,2, 5'b01000);
    tbl[11] = v(1,1,0,0,0, 0,0,0,    10,59,59,3, 5'b01000);
    tbl[12] = v(1,1,1,0,0, 0,0,0,    12,0,0,0,   5'b11010);
    tbl[13] = v(0,1,1,1,0, 0,0,0,    12,0,0,0,   5'b11000);
    tbl[14] = v(0,1,0,0,1, 24,0,0,   12,0,0,0,   5'b10100);
    tbl[15] = v(0,1,0,0,0, 0,0,0,    12,0,0,0,   5'b11000);
    tbl[16] = v(0,1,0,0,1, 12,60,0,  12,0,0,0,   5'b10100);
    tbl[17] = v(0,1,0,0,0, 0,0,0,    12,0,0,0,   5'b11000);
    tbl[18] = v(0,1,0,0,1, 5,6,7,    5,6,7,0,    5'b00000);
    tbl[19] = v(0,1,0,0,1, 13,0,0,   5,6,7,0,    5'b01000);
    tbl[20] = v(0,1,0,0,1, 13,0,0,   13,0,0,0,   5'b10000);
    tbl[21] = v(0,0,0,0,0, 0,0,0,    1,0,0,0,    5'b11000);

    // Reset state, 12-hour mode shows hour 12.
    #22;
    check("reset_disp_12h", disp_time, pk(12, 0, 0, 0));
    check("reset_flags", {pm, set_ready, set_err, sec_pulse, day_pulse}, 5'b01000);
    mode_24 = 1'b1;
    #1;
    check("reset_disp_24h", disp_time, pk(0, 0, 0, 0));

    // Free run from reset: first edge holds, then one tick per edge.
    reset_n = 1'b1;
    run = 1'b1;
    for (int k = 1; k <= 241; k++) begin
      int t;
      step();
      t = k - 1;
      check($sformatf("run_disp_%0d", k), disp_time,
            pk(0, t / (60 * TPS), (t / TPS) % 60, t % TPS));
      check($sformatf("run_secp_%0d", k), sec_pulse, (t > 0 && t % TPS == 0));
    end
    check("run_one_minute", disp_time, pk(0, 1, 0, 0));

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      run = tbl[i].run; mode_24 = tbl[i].m24; spring_fwd = tbl[i].sf;
      fall_back = tbl[i].fb; set_valid = tbl[i].sv; set_time = tbl[i].stime;
      step();
      check($sformatf("vec%0d_disp", i), disp_time, pk(tbl[i].hr, tbl[i].mn, tbl[i].sc, tbl[i].sb));
      check($sformatf("vec%0d_flags", i), {pm, set_ready, set_err, sec_pulse, day_pulse}, tbl[i].flags);
    end
    run = 0; spring_fwd = 0; fall_back = 0; set_valid = 0;

    // Mode switch is visible in the same cycle (state is 13:00:00).
    mode_24 = 1'b1;
    #1;
    check("mode_switch_same_cycle", disp_time, pk(13, 0, 0, 0));

    // Fall-back once per day; re-armed by the day wrap.
    set_valid = 1; set_time = st(2, 0, 0);
    step();
    set_valid = 0; fall_back = 1;
    step();
    check("fb_first", disp_time, pk(1, 0, 0, 0));
    step();
    check("fb_ignored", disp_time, pk(1, 0, 0, 0));
    fall_back = 0; spring_fwd = 1;
    for (int i = 0; i < 22; i++) step();
    check("sf_to_23", disp_time, pk(23, 0, 0, 0));
    spring_fwd = 0; run = 1;
    n = 0; seen = 0;
    while (!seen && n < 16000) begin
      step();
      n++;
      seen = day_pulse;
    end
    check("day_wrap_ticks", n, HT);
    check("day_wrap_time", disp_time, pk(0, 0, 0, 0));
    run = 0; fall_back = 1;
    step();
    check("fb_rearmed", disp_time, pk(23, 0, 0, 0));
    fall_back = 0;

    // Asynchronous reset while BUSY and counting.
    run = 1; set_valid = 1; set_time = st(5, 0, 0);
    step();
    set_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {disp_time, pm, set_ready, set_err, sec_pulse, day_pulse},
          {pk(0, 0, 0, 0), 5'b01000});

    // Randomized run against the reference model.
    #10 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      run = ($urandom_range(7) != 0);
      mode_24 = $urandom_range(1);
      spring_fwd = ($urandom_range(49) == 0);
      fall_back = ($urandom_range(29) == 0);
      set_valid = ($urandom_range(29) == 0);
      r = $urandom_range(3);
      if (r == 0)      set_time = st(23, 59, $urandom_range(59, 56));
      else if (r == 1) set_time = st($urandom_range(31), $urandom_range(63), $urandom_range(63));
      else             set_time = st($urandom_range(23), $urandom_range(59), $urandom_range(59));
      model_edge();
      step();
      check($sformatf("rand%0d", i),
            {disp_time, pm, set_ready, set_err, sec_pulse, day_pulse},
            {model_disp(mode_24), (m_t / HT) >= 12, !m_busy, m_err, m_sp, m_dp});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
